router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 The block SHALL have no parameters; state encoding is internal and fixed.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pkt_valid  input  1  high while header/payload bytes arrive; falls on the parity byte.
REQ-005 data_in  input  2  header address bits [1:0]; 0/1/2 = destination FIFO, 3 = invalid.
REQ-006 fifo_full  input  1  full flag of the currently addressed FIFO.
REQ-007 fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  empty flags of the three output FIFOs.
REQ-008 soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  per-FIFO soft-reset (read timeout).
REQ-009 parity_done  input  1  parity byte has been written.
REQ-010 low_packet_valid  input  1  pkt_valid fell while the FIFO was full.
REQ-011 fifo_addr  output  2  address latched from data_in in DECODE_ADDRESS.
REQ-012 detect_add, lfd_state, ld_state, laf_state, full_state  output  1 each  state-decode strobes.
REQ-013 write_enb_reg  output  1  enables a write into the addressed FIFO.
REQ-014 rst_int_reg  output  1  clears internal parity/low_packet registers.
REQ-015 busy  output  1  stalls the source; source SHALL hold the current byte while busy=1.

Function
REQ-016 States: DA (DECODE_ADDRESS), LFD (LOAD_FIRST_DATA), LD (LOAD_DATA), LP (LOAD_PARITY), FFS (FIFO_FULL_STATE), LAF (LOAD_AFTER_FULL), WTE (WAIT_TILL_EMPTY), CPE (CHECK_PARITY_ERROR).
REQ-017 Outputs SHALL be Moore, decoded combinationally from the state register; the next state is registered on posedge clock.
REQ-018 Addressed-empty SHALL be fifo_empty_N with N = data_in in DA and N = fifo_addr in every other state.
REQ-019 DA: pkt_valid=1, data_in<3, addressed FIFO empty -> LFD; same with FIFO not empty -> WTE; otherwise stay in DA.
REQ-020 fifo_addr SHALL load data_in on every cycle in DA with pkt_valid=1 and data_in<3, and SHALL hold in all other states.
REQ-021 Header with data_in=3 SHALL be ignored: remain in DA, fifo_addr unchanged.
REQ-022 WTE -> LFD when the addressed FIFO is empty; otherwise stay.
REQ-023 LFD -> LD unconditionally, one cycle.
REQ-024 LD: fifo_full=1 -> FFS (priority); else pkt_valid=0 -> LP; else stay.
REQ-025 FFS -> LAF when fifo_full=0; otherwise stay.
REQ-026 LAF: parity_done=1 -> DA; else low_packet_valid=1 -> LP; else -> LD.
REQ-027 LP -> CPE unconditionally.
REQ-028 CPE: fifo_full=1 -> FFS; else -> DA.
REQ-029 detect_add=DA, lfd_state=LFD, ld_state=LD, laf_state=LAF, full_state=FFS, rst_int_reg=CPE.
REQ-030 write_enb_reg SHALL be 1 in LD, LP and LAF only.
REQ-031 busy SHALL be 0 in DA and LD, and 1 in all other states.
REQ-032 Soft reset of the latched port (soft_reset_N, N=fifo_addr) in any non-DA state SHALL force DA on the next edge, overriding REQ-019..REQ-028.
REQ-033 Soft reset of a non-latched port SHALL have no effect; in DA, soft resets SHALL be ignored.

Reset
REQ-034 reset=1 at a posedge SHALL force state DA and fifo_addr=0, regardless of all other inputs.
REQ-035 While in reset: detect_add=1, busy=0, write_enb_reg=0, and every other strobe=0.
REQ-036 Reset asserted mid-packet SHALL abort it immediately; no write enable SHALL appear on the following cycle.

Verification
REQ-037 Normal packet: header addr=1 with fifo_empty_1=1, 4 payload bytes, then pkt_valid=0 -> DA,LFD,LD x4,LP,CPE,DA; write_enb_reg high for 5 cycles; fifo_addr=1.
REQ-038 Busy target: header addr=2 with fifo_empty_2=0 for 3 cycles -> WTE for 3 cycles with busy=1; fifo_empty_2=1 -> LFD on the next edge.
REQ-039 Full mid-packet: fifo_full=1 in LD -> FFS, write_enb_reg=0; fifo_full=0 -> LAF; parity_done=0, low_packet_valid=1 -> LP.
REQ-040 Invalid address: pkt_valid=1, data_in=3 for 5 cycles -> stays in DA, detect_add=1, fifo_addr unchanged.
REQ-041 Soft reset: in LD with fifo_addr=0, soft_reset_1=1 -> no change; soft_reset_0=1 -> DA next cycle.
REQ-042 Reset in FFS with fifo_full=1 -> DA next cycle, fifo_addr=0, busy=0.

Source files
------------

// File: rtl/router_fsm.sv
// Packet router control FSM: decodes the header address, sequences payload and parity
// writes into the addressed FIFO, and stalls the source while the target is busy or full.
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic [1:0] fifo_addr,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {DA, LFD, LD, LP, FFS, LAF, WTE, CPE} state_t;

  state_t     state, state_nxt;
  logic [1:0] sel;
  logic       addr_empty;
  logic       addr_soft;
  logic       hdr_ok;

  // In DA the header on data_in selects the port; afterwards the latched address does.
  assign sel    = (state == DA) ? data_in : fifo_addr;
  assign hdr_ok = pkt_valid && (data_in != 2'd3);

  always_comb begin
    addr_empty = 1'b0;
    addr_soft  = 1'b0;
    case (sel)
      2'd0:    begin addr_empty = fifo_empty_0; addr_soft = soft_reset_0; end
      2'd1:    begin addr_empty = fifo_empty_1; addr_soft = soft_reset_1; end
      2'd2:    begin addr_empty = fifo_empty_2; addr_soft = soft_reset_2; end
      default: begin addr_empty = 1'b0;         addr_soft = 1'b0;         end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= DA;
      fifo_addr <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == DA && hdr_ok) fifo_addr <= data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DA:      if (hdr_ok) state_nxt = addr_empty ? LFD : WTE;
      WTE:     if (addr_empty) state_nxt = LFD;
      LFD:     state_nxt = LD;
      LD:      if (fifo_full) state_nxt = FFS;
               else if (!pkt_valid) state_nxt = LP;
      FFS:     if (!fifo_full) state_nxt = LAF;
      LAF:     if (parity_done) state_nxt = DA;
               else if (low_packet_valid) state_nxt = LP;
               else state_nxt = LD;
      LP:      state_nxt = CPE;
      CPE:     state_nxt = fifo_full ? FFS : DA;
      default: state_nxt = DA;
    endcase
    // A read timeout on the latched port abandons the packet from any active state.
    if (state != DA && addr_soft) state_nxt = DA;
  end

  assign detect_add    = (state == DA);
  assign lfd_state     = (state == LFD);
  assign ld_state      = (state == LD);
  assign laf_state     = (state == LAF);
  assign full_state    = (state == FFS);
  assign rst_int_reg   = (state == CPE);
  assign write_enb_reg = (state == LD) || (state == LP) || (state == LAF);
  assign busy          = !((state == DA) || (state == LD));

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed vector table, a wait-till-empty sequence, and a
// randomized run checked against a packet-level reference model.
module tb_router_fsm;

  localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_LP = 3, S_FFS = 4, S_LAF = 5, S_WTE = 6, S_CPE = 7;

  typedef struct packed {
    logic       rst;
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
  } in_t;

  typedef struct {
    in_t        i;
    int         es;
    logic [1:0] ea;
  } vec_t;

  logic clock = 1'b0;
  in_t  cur;
  logic [1:0] fifo_addr;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy;

  int checks = 0;
  int errors = 0;
  int         ms = S_DA;
  logic [1:0] ma = 2'd0;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock(clock), .reset(cur.rst), .pkt_valid(cur.pv), .data_in(cur.din),
    .fifo_full(cur.full),
    .fifo_empty_0(cur.emp[0]), .fifo_empty_1(cur.emp[1]), .fifo_empty_2(cur.emp[2]),
    .soft_reset_0(cur.sr[0]), .soft_reset_1(cur.sr[1]), .soft_reset_2(cur.sr[2]),
    .parity_done(cur.pd), .low_packet_valid(cur.lpv),
    .fifo_addr(fifo_addr), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
  );

  function automatic in_t mk(logic rst, logic pv, logic [1:0] din, logic full,
                             logic [2:0] emp, logic [2:0] sr, logic pd, logic lpv);
    in_t r;
    r.rst = rst; r.pv = pv; r.din = din; r.full = full;
    r.emp = emp; r.sr = sr; r.pd = pd; r.lpv = lpv;
    return r;
  endfunction

  // Expected output word {detect,lfd,ld,laf,full,rst_int,we,busy,addr[1:0]} for a phase.
  function automatic logic [9:0] outs(int s, logic [1:0] a);
    logic we, bz;
    we = (s == S_LD) || (s == S_LP) || (s == S_LAF);
    bz = !((s == S_DA) || (s == S_LD));
    return {s == S_DA, s == S_LFD, s == S_LD, s == S_LAF, s == S_FFS, s == S_CPE, we, bz, a};
  endfunction

  function automatic int mnext(int s, logic [1:0] a, in_t i);
    int n;
    n = s;
    if (s == S_DA) begin
      if (i.pv && i.din != 2'd3) n = i.emp[i.din] ? S_LFD : S_WTE;
    end else if (s == S_WTE) n = i.emp[a] ? S_LFD : S_WTE;
    else if (s == S_LFD) n = S_LD;
    else if (s == S_LD)  n = i.full ? S_FFS : (!i.pv ? S_LP : S_LD);
    else if (s == S_FFS) n = i.full ? S_FFS : S_LAF;
    else if (s == S_LAF) n = i.pd ? S_DA : (i.lpv ? S_LP : S_LD);
    else if (s == S_LP)  n = S_CPE;
    else if (s == S_CPE) n = i.full ? S_FFS : S_DA;
    if (s != S_DA && i.sr[a]) n = S_DA;
    return n;
  endfunction

  function automatic logic [9:0] got();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
            write_enb_reg, busy, fifo_addr};
  endfunction

  task automatic chk(string name, logic [9:0] exp);
    checks++;
    if (got() !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got(), exp, $time);
    end
  endtask

  // Advance one clock edge, stepping the reference model with the inputs seen at that edge.
  task automatic tick();
    int sn;
    logic [1:0] an;
    sn = ms; an = ma;
    if (cur.rst) begin
      sn = S_DA; an = 2'd0;
    end else begin
      if (ms == S_DA && cur.pv && cur.din != 2'd3) an = cur.din;
      sn = mnext(ms, ma, cur);
    end
    @(posedge clock); #1;
    ms = sn; ma = an;
  endtask

  vec_t tbl[$];

  initial begin
    cur = mk(1, 0, 0, 0, 3'b000, 3'b000, 0, 0);
    // reset state
    tbl.push_back('{mk(1, 1, 2, 1, 3'b111, 3'b111, 1, 1), S_DA, 2'd0});
    // normal packet to port 1
    tbl.push_back('{mk(0, 1, 1, 0, 3'b010, 3'b000, 0, 0), S_LFD, 2'd1});
    tbl.push_back('{mk(0, 1, 0, 0, 3'b010, 3'b000, 0, 0), S_LD,  2'd1});
    tbl.push_back('{mk(0, 1, 2, 0, 3'b010, 3'b000, 0, 0), S_LD,  2'd1});
    tbl.push_back('{mk(0, 1, 3, 0, 3'b010, 3'b000, 0, 0), S_LD,  2'd1});
    tbl.push_back('{mk(0, 1, 0, 0, 3'b010, 3'b000, 0, 0), S_LD,  2'd1});
    tbl.push_back('{mk(0, 0, 0, 0, 3'b010, 3'b000, 0, 0), S_LP,  2'd1});
    tbl.push_back('{mk(0, 0, 0, 0, 3'b010, 3'b000, 1, 0), S_CPE, 2'd1});
    tbl.push_back('{mk(0, 0, 0, 0, 3'b010, 3'b000, 0, 0), S_DA,  2'd1});
    // invalid address for 5 cycles
    for (int k = 0; k < 5; k++)
      tbl.push_back('{mk(0, 1, 3, 0, 3'b111, 3'b000, 0, 0), S_DA, 2'd1});
    // full mid-packet, resume via low_packet_valid
    tbl.push_back('{mk(0, 1, 0, 0, 3'b001, 3'b000, 0, 0), S_LFD, 2'd0});
    tbl.push_back('{mk(0, 1, 0, 0, 3'b001, 3'b000, 0, 0), S_LD,  2'd0});
    tbl.push_back('{mk(0, 1, 0, 1, 3'b001, 3'b000, 0, 0), S_FFS, 2'd0});
    tbl.push_back('{mk(0, 0, 0, 1, 3'b001, 3'b000, 0, 0), S_FFS, 2'd0});
    tbl.push_back('{mk(0, 0, 0, 0, 3'b001, 3'b000, 0, 1), S_LAF, 2'd0});
    tbl.push_back('{mk(0, 0, 0, 0, 3'b001, 3'b000, 0, 1), S_LP,  2'd0});
    tbl.push_back('{mk(0, 0, 0, 1, 3'b001, 3'b000, 0, 0), S_CPE, 2'd0});
    tbl.push_back('{mk(0, 0, 0, 1, 3'b001, 3'b000, 0, 0), S_FFS, 2'd0});
    tbl.push_back('{mk(0, 0, 0, 0, 3'b001, 3'b000, 0, 0), S_LAF, 2'd0});
    tbl.push_back('{mk(0, 0, 0, 0, 3'b001, 3'b000, 1, 0), S_DA,  2'd0});
    // soft reset: non-latched port ignored, latched port aborts; DA ignores soft reset
    tbl.push_back('{mk(0, 1, 0, 0, 3'b001, 3'b111, 0, 0), S_LFD, 2'd0});
    tbl.push_back('{mk(0, 1, 0, 0, 3'b001, 3'b000, 0, 0), S_LD,  2'd0});
    tbl.push_back('{mk(0, 1, 0, 0, 3'b001, 3'b010, 0, 0), S_LD,  2'd0});
    tbl.push_back('{mk(0, 1, 0, 0, 3'b001, 3'b001, 0, 0), S_DA,  2'd0});
    // reset while stalled on a full FIFO
    tbl.push_back('{mk(0, 1, 2, 0, 3'b100, 3'b000, 0, 0), S_LFD, 2'd2});
    tbl.push_back('{mk(0, 1, 2, 0, 3'b100, 3'b000, 0, 0), S_LD,  2'd2});
    tbl.push_back('{mk(0, 1, 2, 1, 3'b100, 3'b000, 0, 0), S_FFS, 2'd2});
    tbl.push_back('{mk(1, 1, 2, 1, 3'b100, 3'b000, 0, 0), S_DA,  2'd0});
    // reset mid-payload: no write enable after the edge
    tbl.push_back('{mk(0, 1, 1, 0, 3'b010, 3'b000, 0, 0), S_LFD, 2'd1});
    tbl.push_back('{mk(0, 1, 1, 0, 3'b010, 3'b000, 0, 0), S_LD,  2'd1});
    tbl.push_back('{mk(1, 1, 1, 0, 3'b010, 3'b000, 0, 0), S_DA,  2'd0});

    foreach (tbl[k]) begin
      cur = tbl[k].i;
      tick();
      chk($sformatf("vec%0d", k), outs(tbl[k].es, tbl[k].ea));
    end

    // wait-till-empty: port 2 stays non-empty for 3 cycles, then drains
    cur = mk(0, 1, 2, 0, 3'b000, 3'b000, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("wte%0d", k), outs(S_WTE, 2'd2));
    end
    cur.emp = 3'b100;
    tick();
    chk("wte_to_lfd", outs(S_LFD, 2'd2));
    tick();
    chk("wte_then_ld", outs(S_LD, 2'd2));

    // randomized run against the reference model
    for (int k = 0; k < 3000; k++) begin
      cur.rst  = ($urandom_range(0, 63) == 0);
      cur.pv   = ($urandom_range(0, 7) != 0);
      cur.din  = 2'($urandom_range(0, 3));
      cur.full = ($urandom_range(0, 3) == 0);
      cur.emp  = 3'($urandom_range(0, 7));
      cur.sr   = {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 31) == 0)};
      cur.pd   = ($urandom_range(0, 3) == 0);
      cur.lpv  = ($urandom_range(0, 3) == 0);
      tick();
      chk($sformatf("rand%0d", k), outs(ms, ma));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
